receptor_serial: RTL
====================

# receptor_serial

Serial receiver for the single-wire frame produced by the team's serial transmitter. Samples `Date_seriale` once per `Ceas` cycle (one bit per clock, no oversampling), detects the start bit, deserialises 8 data bits MSB first, checks parity and stop bit, and presents the byte with a one-cycle completion pulse. Sits at the far end of the serial link and feeds byte-parallel consumers.

## Interface
- `PARITATE_IMPARA`, default 0: 0 selects even parity (parity bit = XOR of the 8 data bits); 1 selects odd parity (inverted XOR).
- `Ceas`  input  1: clock; all state updates on the rising edge.
- `Reset`  input  1: asynchronous, active-high reset.
- `Date_seriale`  input  1: serial line; idle level 1.
- `Date_primite`  output  8: last received byte; holds until the next completed frame.
- `Gata_receptie`  output  1: one-cycle pulse per completed frame, error or not.
- `Eroare_paritate`  output  1: parity mismatch on last frame; valid with and held after `Gata_receptie`.
- `Eroare_cadru`  output  1: stop bit sampled 0 on last frame; valid with and held after `Gata_receptie`.
- `Ocupat`  output  1: high from the cycle after the start bit is sampled until the frame ends.

## Operation
- Frame on the line, one bit per cycle: start (0), D7, D6, …, D0, parity, stop (1); 11 bits. Idle is 1.
- States: ASTEPTARE, DATE, PARITATE, STOP, RECUPERARE.
- ASTEPTARE: sampled bit 0 -> DATE, bit counter cleared. Sampled bit 1 -> stay.
- DATE: shift the sampled bit into the LSB of the shift register (MSB arrives first). After the 8th bit -> PARITATE. 4-bit counter, counts 0..7, no wrap beyond 7.
- PARITATE: compute the expected parity from the shift register per `PARITATE_IMPARA` and compare with the sampled bit. Latch the mismatch -> STOP.
- STOP, on the sampling edge:
  - load `Date_primite` from the shift register
  - update both error flags
  - assert `Gata_receptie` for the following cycle
  - sampled 1 -> ASTEPTARE; sampled 0 -> RECUPERARE with `Eroare_cadru` = 1.
- RECUPERARE: wait for a sampled 1, then go to ASTEPTARE. A 0 stop bit is never taken as a new start bit.
- Error flags are overwritten each frame; they are not sticky across frames.
- Reset values: `Date_primite` = 8'h00, `Gata_receptie`, `Eroare_paritate`, `Eroare_cadru` and `Ocupat` = 0, state ASTEPTARE, shift register and counter cleared.

## Timing
- Start bit sampled at edge k. Data at edges k+1..k+8, parity at k+9, stop at k+10.
- `Date_primite`, the error flags and `Gata_receptie` are updated by edge k+10. `Gata_receptie` is high for the cycle k+10..k+11 only.
- `Ocupat` is 1 after edge k and 0 after edge k+10.
- Back-to-back frames: a start bit at edge k+11 is accepted. Zero idle bits between frames is legal.
- Reset asserted mid-frame: all state and outputs clear immediately and asynchronously. The partial frame is discarded with no `Gata_receptie`. The first edge after deassertion samples in ASTEPTARE.
- A line held at 0 after reset is taken as a start bit.

## Configuration
- `RECEPTOR_SINCRONIZARE_EN` defined: `Date_seriale` passes through a two-flop synchroniser (reset value 1) before the FSM. Every timing figure above shifts by +2 cycles relative to the pin.
- Not defined: `Date_seriale` is sampled directly, with timing as stated above. Use this only when the transmitter shares `Ceas`.

## Test plan
- Reset, line idle 1 for 5 cycles -> all outputs 0, `Date_primite` = 8'h00, no `Gata_receptie`.
- Frame 0, 1,0,1,0,0,1,0,1 (8'hA5), parity 0, stop 1, with `PARITATE_IMPARA` = 0 -> `Date_primite` = 8'hA5, `Gata_receptie` pulses once 10 cycles after the start edge, both errors 0.
- 8'h3C with parity bit 1 (wrong for even) -> `Date_primite` = 8'h3C, `Eroare_paritate` = 1, `Eroare_cadru` = 0.
- 8'hFF with stop bit 0, then line 0 for 3 cycles, then 1, then a valid 8'h01 frame:
  - first frame: `Eroare_cadru` = 1
  - the held 0s: no new frame starts
  - 8'h01 frame: received with both errors 0.
- Frames 8'h12 and 8'h34 back to back with no idle bit -> two `Gata_receptie` pulses 11 cycles apart, bytes in order.
- `Reset` asserted after the 4th data bit of 8'hC3, released, then a full 8'h5A frame -> no pulse for 8'hC3, 8'h5A received correctly.

Source files
------------

// File: rtl/receptor_serial.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : receptor_serial                                                 |
// | Brief    : Single-wire serial frame receiver, one bit per clock cycle.     |
// |            Frame: start(0), D7..D0, parity, stop(1). The byte is presented |
// |            in parallel together with a one-cycle completion pulse and the  |
// |            parity / framing error flags.                                   |
// | Option   : RECEPTOR_SINCRONIZARE_EN - route Date_seriale through a         |
// |            two-flop synchroniser (adds two cycles of latency).             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module receptor_serial #(
   parameter bit PARITATE_IMPARA = 1'b0
) (
   input  logic       Ceas,
   input  logic       Reset,
   input  logic       Date_seriale,
   output logic [7:0] Date_primite,
   output logic       Gata_receptie,
   output logic       Eroare_paritate,
   output logic       Eroare_cadru,
   output logic       Ocupat
);

   // Index of the last data bit; the counter stops here.
   localparam logic [3:0] c_ULTIM_BIT = 4'd7;

   typedef enum logic [2:0] {
      ASTEPTARE  = 3'd0,
      DATE       = 3'd1,
      PARITATE   = 3'd2,
      STOP       = 3'd3,
      RECUPERARE = 3'd4
   } stare_t;

   stare_t      stare_q;
   logic [7:0]  deplasare_q;
   logic [3:0]  contor_q;
   logic        eroare_par_q;

   logic [7:0]  date_primite_q;
   logic        gata_q;
   logic        eroare_paritate_q;
   logic        eroare_cadru_q;
   logic        ocupat_q;

   logic        w_bit;
   logic        w_paritate_asteptata;

`ifdef RECEPTOR_SINCRONIZARE_EN
   logic [1:0]  sincr_q;

   // Two-flop synchroniser; resets to the idle line level so no false start.
   always_ff @(posedge Ceas or posedge Reset) begin
      if (Reset) begin
         sincr_q <= 2'b11;
      end else begin
         sincr_q <= {sincr_q[0], Date_seriale};
      end
   end

   assign w_bit = sincr_q[1];
`else
   assign w_bit = Date_seriale;
`endif

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   assign w_paritate_asteptata = (^deplasare_q) ^ PARITATE_IMPARA;

   // Frame state machine with registered outputs.
   always_ff @(posedge Ceas or posedge Reset) begin
      if (Reset) begin
         stare_q           <= ASTEPTARE;
         deplasare_q       <= 8'h00;
         contor_q          <= 4'd0;
         eroare_par_q      <= 1'b0;
         date_primite_q    <= 8'h00;
         gata_q            <= 1'b0;
         eroare_paritate_q <= 1'b0;
         eroare_cadru_q    <= 1'b0;
         ocupat_q          <= 1'b0;
      end else begin
         // Completion is a single-cycle pulse unless STOP re-asserts it.
         gata_q <= 1'b0;

         case (stare_q)
            ASTEPTARE: begin
               if (!w_bit) begin
                  stare_q  <= DATE;
                  contor_q <= 4'd0;
                  ocupat_q <= 1'b1;
               end
            end

            DATE: begin
               // MSB arrives first, so shift toward the MSB end.
               deplasare_q <= {deplasare_q[6:0], w_bit};
               if (contor_q == c_ULTIM_BIT) begin
                  stare_q <= PARITATE;
               end else begin
                  contor_q <= contor_q + 4'd1;
               end
            end

            PARITATE: begin
               eroare_par_q <= (w_bit != w_paritate_asteptata);
               stare_q      <= STOP;
            end

            STOP: begin
               date_primite_q    <= deplasare_q;
               eroare_paritate_q <= eroare_par_q;
               eroare_cadru_q    <= ~w_bit;
               gata_q            <= 1'b1;
               ocupat_q          <= 1'b0;
               // A low stop bit must not be mistaken for the next start bit.
               stare_q           <= w_bit ? ASTEPTARE : RECUPERARE;
            end

            RECUPERARE: begin
               if (w_bit) begin
                  stare_q <= ASTEPTARE;
               end
            end

            default: begin
               stare_q  <= ASTEPTARE;
               ocupat_q <= 1'b0;
            end
         endcase
      end
   end

   assign Date_primite    = date_primite_q;
   assign Gata_receptie   = gata_q;
   assign Eroare_paritate = eroare_paritate_q;
   assign Eroare_cadru    = eroare_cadru_q;
   assign Ocupat          = ocupat_q;

endmodule
`default_nettype wire
